// File: rtl/date_counter.sv
// Calendar register: holds DD-MM-YY in BCD plus weekday, loads validated
// user dates and advances one day per midnight tick.
module date_counter #(
  parameter logic [2:0] RESET_WEEKDAY = 3'd6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [3:0] ld_day1,
  input  logic [3:0] ld_day2,
  input  logic [3:0] ld_month1,
  input  logic [3:0] ld_month2,
  input  logic [3:0] ld_year1,
  input  logic [3:0] ld_year2,
  input  logic [2:0] ld_weekday,
  input  logic       day_tick,
  output logic [3:0] day1,
  output logic [3:0] day2,
  output logic [3:0] month1,
  output logic [3:0] month2,
  output logic [3:0] year1,
  output logic [3:0] year2,
  output logic [2:0] weekday,
  output logic       load_err,
  output logic       new_year
);

  logic [3:0] day1_q, day1_d, day2_q, day2_d;
  logic [3:0] month1_q, month1_d, month2_q, month2_d;
  logic [3:0] year1_q, year1_d, year2_q, year2_d;
  logic [2:0] weekday_q, weekday_d;
  logic       load_err_q, load_err_d;
  logic       new_year_q, new_year_d;

  logic [7:0] ld_len, cur_len;
  logic       ld_digits_ok, ld_month_ok, ld_day_ok, ld_ok;

  // Month length returned in BCD so it compares directly against the day digits.
  function automatic logic [7:0] month_len(input logic [3:0] m1, input logic [3:0] m2,
                                           input logic [3:0] y1, input logic [3:0] y2);
    logic leap;
    leap = y1[0] ? ((y2 == 4'd2) || (y2 == 4'd6))
                 : ((y2 == 4'd0) || (y2 == 4'd4) || (y2 == 4'd8));
    case ({m1, m2})
      8'h02:                      month_len = leap ? 8'h29 : 8'h28;
      8'h04, 8'h06, 8'h09, 8'h11: month_len = 8'h30;
      default:                    month_len = 8'h31;
    endcase
  endfunction

  always_comb begin
    ld_len       = month_len(ld_month1, ld_month2, ld_year1, ld_year2);
    cur_len      = month_len(month1_q, month2_q, year1_q, year2_q);
    ld_digits_ok = (ld_day1 <= 4'd9) && (ld_day2 <= 4'd9) &&
                   (ld_month1 <= 4'd9) && (ld_month2 <= 4'd9) &&
                   (ld_year1 <= 4'd9) && (ld_year2 <= 4'd9) &&
                   (ld_weekday <= 3'd6);
    ld_month_ok  = ((ld_month1 == 4'd0) && (ld_month2 != 4'd0)) ||
                   ((ld_month1 == 4'd1) && (ld_month2 <= 4'd2));
    // Plain 8-bit compare is a valid BCD compare once every digit is <= 9.
    ld_day_ok    = ({ld_day1, ld_day2} != 8'h00) && ({ld_day1, ld_day2} <= ld_len);
    ld_ok        = ld_digits_ok && ld_month_ok && ld_day_ok;
  end

  always_comb begin
    day1_d     = day1_q;
    day2_d     = day2_q;
    month1_d   = month1_q;
    month2_d   = month2_q;
    year1_d    = year1_q;
    year2_d    = year2_q;
    weekday_d  = weekday_q;
    load_err_d = 1'b0;
    new_year_d = 1'b0;

    if (load) begin
      if (ld_ok) begin
        day1_d    = ld_day1;
        day2_d    = ld_day2;
        month1_d  = ld_month1;
        month2_d  = ld_month2;
        year1_d   = ld_year1;
        year2_d   = ld_year2;
        weekday_d = ld_weekday;
      end else begin
        load_err_d = 1'b1;
      end
    end else if (day_tick) begin
      weekday_d = (weekday_q == 3'd6) ? 3'd0 : weekday_q + 3'd1;
      if ({day1_q, day2_q} == cur_len) begin
        day1_d = 4'd0;
        day2_d = 4'd1;
        if ({month1_q, month2_q} == 8'h12) begin
          month1_d   = 4'd0;
          month2_d   = 4'd1;
          new_year_d = 1'b1;
          if (year2_q == 4'd9) begin
            year2_d = 4'd0;
            year1_d = (year1_q == 4'd9) ? 4'd0 : year1_q + 4'd1;
          end else begin
            year2_d = year2_q + 4'd1;
          end
        end else if (month2_q == 4'd9) begin
          month1_d = 4'd1;
          month2_d = 4'd0;
        end else begin
          month2_d = month2_q + 4'd1;
        end
      end else if (day2_q == 4'd9) begin
        day2_d = 4'd0;
        day1_d = day1_q + 4'd1;
      end else begin
        day2_d = day2_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      day1_q     <= 4'd0;
      day2_q     <= 4'd1;
      month1_q   <= 4'd0;
      month2_q   <= 4'd1;
      year1_q    <= 4'd0;
      year2_q    <= 4'd0;
      weekday_q  <= RESET_WEEKDAY;
      load_err_q <= 1'b0;
      new_year_q <= 1'b0;
    end else begin
      day1_q     <= day1_d;
      day2_q     <= day2_d;
      month1_q   <= month1_d;
      month2_q   <= month2_d;
      year1_q    <= year1_d;
      year2_q    <= year2_d;
      weekday_q  <= weekday_d;
      load_err_q <= load_err_d;
      new_year_q <= new_year_d;
    end
  end

  assign day1     = day1_q;
  assign day2     = day2_q;
  assign month1   = month1_q;
  assign month2   = month2_q;
  assign year1    = year1_q;
  assign year2    = year2_q;
  assign weekday  = weekday_q;
  assign load_err = load_err_q;
  assign new_year = new_year_q;

endmodule
